// File: rtl/systolic_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_seq_ctrl_if
//  Description : Input-vector stream handshake for the systolic sequencer.
//                The producer drives x_vld_i/x_data_i and the sequencer
//                returns x_rdy_o. Element r of a vector sits in bits
//                [r*X_W +: X_W] of x_data_i.
//  Signals     : x_vld_i   1          vector valid
//                x_data_i  ROWS*X_W   vector payload
//                x_rdy_o   1          sequencer ready
//  Revision    : 1.0  initial release
// ============================================================================
interface systolic_seq_ctrl_if #(
   parameter int ROWS = 8,
   parameter int X_W  = 8
);
   logic                x_vld_i;
   logic [ROWS*X_W-1:0] x_data_i;
   logic                x_rdy_o;

   modport master (output x_vld_i, output x_data_i, input  x_rdy_o);
   modport slave  (input  x_vld_i, input  x_data_i, output x_rdy_o);
endinterface
`default_nettype wire

// File: rtl/systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : systolic_seq_ctrl
//  Description : Job sequencer for a ROWS x COLS weight-stationary systolic
//                array. Loads one weight row per cycle, streams input vectors
//                over a valid/ready handshake with a diagonal skew into the
//                array, waits for the last partial sum to drain, then pulses
//                done_o.
//  Ports       : clk_i, rst_i     clock, synchronous active-high reset
//                start_i          job start (sampled in IDLE only)
//                num_vec_i        vectors in the job (latched on start)
//                abort_i          synchronous abort back to IDLE
//                x_if             input vector handshake (slave side)
//                w_ld_o, w_row_o  weight row load strobe and row index
//                x_row_v_o/_d_o   skewed per-row valid/data into column 0
//                top_mac_v_o      skewed mac valid into each column top PE
//                busy_o, done_o   job activity and completion pulse
//  Revision    : 1.0  initial release
// ============================================================================
module systolic_seq_ctrl #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int X_W   = 8,
   parameter int CNT_W = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic [CNT_W-1:0]          num_vec_i,
   input  logic                      abort_i,
   systolic_seq_ctrl_if.slave        x_if,
   output logic                      w_ld_o,
   output logic [$clog2(ROWS)-1:0]   w_row_o,
   output logic [ROWS-1:0]           x_row_v_o,
   output logic [ROWS*X_W-1:0]       x_row_d_o,
   output logic [COLS-1:0]           top_mac_v_o,
   output logic                      busy_o,
   output logic                      done_o
);
   localparam int RW    = $clog2(ROWS);
   localparam int DRN_W = $clog2(ROWS + COLS + 1);
   // One valid shift register serves both the row valids and the column mac
   // valids, since both follow the same t+1+index timing.
   localparam int SKW   = (ROWS > COLS) ? ROWS : COLS;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_W = 3'd1,
      S_STREAM = 3'd2,
      S_DRAIN  = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t             state_q,   state_d;
   logic [CNT_W-1:0]   num_vec_q, num_vec_d;
   logic [CNT_W-1:0]   vec_cnt_q, vec_cnt_d;
   logic [RW-1:0]      ld_cnt_q,  ld_cnt_d;
   logic [DRN_W-1:0]   drn_cnt_q, drn_cnt_d;
   logic [SKW-1:0]     hs_sr_q,   hs_sr_d;

   logic               clr;
   logic               hs;

   // Abort behaves exactly like reset, so both feed one clear term.
   assign clr = rst_i | abort_i;
   assign hs  = (state_q == S_STREAM) & x_if.x_vld_i;

   always_comb begin
      state_d   = state_q;
      num_vec_d = num_vec_q;
      vec_cnt_d = vec_cnt_q;
      ld_cnt_d  = ld_cnt_q;
      drn_cnt_d = drn_cnt_q;
      hs_sr_d   = {hs_sr_q[SKW-2:0], hs};

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               num_vec_d = num_vec_i;
               vec_cnt_d = '0;
               ld_cnt_d  = '0;
               state_d   = (num_vec_i == '0) ? S_DONE : S_LOAD_W;
            end
         end
         S_LOAD_W: begin
            if (ld_cnt_q == RW'(ROWS - 1)) begin
               ld_cnt_d = '0;
               state_d  = S_STREAM;
            end else begin
               ld_cnt_d = ld_cnt_q + 1'b1;
            end
         end
         S_STREAM: begin
            if (hs) begin
               vec_cnt_d = vec_cnt_q + 1'b1;
               if ((vec_cnt_q + 1'b1) == num_vec_q) begin
                  // Count-to-zero gives exactly ROWS+COLS drain cycles.
                  drn_cnt_d = DRN_W'(ROWS + COLS - 1);
                  state_d   = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (drn_cnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               drn_cnt_d = drn_cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (clr) begin
         state_q   <= S_IDLE;
         num_vec_q <= '0;
         vec_cnt_q <= '0;
         ld_cnt_q  <= '0;
         drn_cnt_q <= '0;
         hs_sr_q   <= '0;
      end else begin
         state_q   <= state_d;
         num_vec_q <= num_vec_d;
         vec_cnt_q <= vec_cnt_d;
         ld_cnt_q  <= ld_cnt_d;
         drn_cnt_q <= drn_cnt_d;
         hs_sr_q   <= hs_sr_d;
      end
   end

   // Row r data passes through r+1 registers so it meets the array one
   // cycle per row later than row 0. Non-handshake slots carry zero.
   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [X_W-1:0] dat_q [r+1];
      logic [X_W-1:0] dat_d [r+1];

      always_comb begin
         dat_d[0] = hs ? x_if.x_data_i[r*X_W +: X_W] : '0;
         for (int k = 1; k <= r; k++) begin
            dat_d[k] = dat_q[k-1];
         end
      end

      always_ff @(posedge clk_i) begin
         for (int k = 0; k <= r; k++) begin
            if (clr) begin
               dat_q[k] <= '0;
            end else begin
               dat_q[k] <= dat_d[k];
            end
         end
      end

      assign x_row_d_o[r*X_W +: X_W] = dat_q[r];
   end

   assign x_row_v_o   = hs_sr_q[ROWS-1:0];
   assign top_mac_v_o = hs_sr_q[COLS-1:0];

   // State decodes only; every output comes straight from flops.
   assign x_if.x_rdy_o = (state_q == S_STREAM);
   assign w_ld_o       = (state_q == S_LOAD_W);
   assign w_row_o      = ld_cnt_q;
   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = (state_q == S_DONE);
endmodule
`default_nettype wire

// File: tb/tb_systolic_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_seq_ctrl
//  Description : Directed self-checking bench for systolic_seq_ctrl with a
//                4x4 array. Each cycle the full output set is packed into
//                one word and compared to a hand-derived expectation. Cycle 0
//                of every job is the cycle in which start_i is high.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_systolic_seq_ctrl;
   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int X_W   = 8;
   localparam int CNT_W = 8;
   localparam int RW    = $clog2(ROWS);
   localparam int OW    = 1 + RW + 1 + ROWS + ROWS*X_W + COLS + 1 + 1;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 start;
   logic                 abort;
   logic [CNT_W-1:0]     num_vec;
   logic                 w_ld;
   logic [RW-1:0]        w_row;
   logic [ROWS-1:0]      row_v;
   logic [ROWS*X_W-1:0]  row_d;
   logic [COLS-1:0]      mac_v;
   logic                 busy;
   logic                 done;
   logic [OW-1:0]        obs;

   int checks = 0;
   int passed = 0;

   // Expected-model state: handshake cycles and the vectors accepted there.
   int                   hs_t[$];
   logic [ROWS*X_W-1:0]  hs_v[$];
   logic [ROWS-1:0]      e_v;
   logic [ROWS*X_W-1:0]  e_d;
   logic [COLS-1:0]      e_m;

   always #5 clk = ~clk;

   systolic_seq_ctrl_if #(.ROWS(ROWS), .X_W(X_W)) xif ();

   systolic_seq_ctrl #(
      .ROWS(ROWS), .COLS(COLS), .X_W(X_W), .CNT_W(CNT_W)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .start_i    (start),
      .num_vec_i  (num_vec),
      .abort_i    (abort),
      .x_if       (xif.slave),
      .w_ld_o     (w_ld),
      .w_row_o    (w_row),
      .x_row_v_o  (row_v),
      .x_row_d_o  (row_d),
      .top_mac_v_o(mac_v),
      .busy_o     (busy),
      .done_o     (done)
   );

   assign obs = {w_ld, w_row, xif.x_rdy_o, row_v, row_d, mac_v, busy, done};

   // Distinct element values: high nibble = vector index + 1, low = row + 1.
   function automatic logic [ROWS*X_W-1:0] vec(input int k);
      logic [ROWS*X_W-1:0] v;
      v = '0;
      for (int r = 0; r < ROWS; r++) v[r*X_W +: X_W] = X_W'((k + 1) * 16 + r + 1);
      return v;
   endfunction

   // Handshake at cycle t shows row r at t+1+r and column c at t+1+c.
   task automatic model(input int cyc);
      e_v = '0; e_d = '0; e_m = '0;
      foreach (hs_t[i]) begin
         for (int r = 0; r < ROWS; r++) begin
            if (cyc == hs_t[i] + 1 + r) begin
               e_v[r] = 1'b1;
               e_d[r*X_W +: X_W] = hs_v[i][r*X_W +: X_W];
            end
         end
         for (int c = 0; c < COLS; c++) begin
            if (cyc == hs_t[i] + 1 + c) e_m[c] = 1'b1;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [OW-1:0] exp_w;
      rst = 1'b1; start = 1'b0; abort = 1'b0; num_vec = '0;
      xif.x_vld_i = 1'b0; xif.x_data_i = '0;
      tick();
      tick();
      exp_w = '0;
      checks++;
      if (obs !== exp_w) $display("FAIL reset got=%h exp=%h", obs, exp_w);
      else passed++;
      rst = 1'b0;
      for (int cyc = 0; cyc < 4; cyc++) begin
         tick();
         checks++;
         if (obs !== exp_w) $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, obs, exp_w);
         else passed++;
      end
   endtask

   task automatic test_stream();
      logic [OW-1:0] exp_w;
      logic [RW-1:0] ew;
      hs_t.delete(); hs_v.delete();
      for (int k = 0; k < 3; k++) begin
         hs_t.push_back(5 + k);
         hs_v.push_back(vec(k));
      end
      start = 1'b1; num_vec = 8'd3; xif.x_vld_i = 1'b1; xif.x_data_i = '0;
      for (int cyc = 1; cyc <= 18; cyc++) begin
         tick();
         start = 1'b0;
         xif.x_data_i = (cyc >= 5 && cyc <= 7) ? vec(cyc - 5) : '0;
         model(cyc);
         ew = (cyc >= 1 && cyc <= 4) ? RW'(cyc - 1) : '0;
         exp_w = {(cyc >= 1 && cyc <= 4), ew, (cyc >= 5 && cyc <= 7),
                  e_v, e_d, e_m, (cyc <= 16), (cyc == 16)};
         checks++;
         if (obs !== exp_w) $display("FAIL stream cyc=%0d got=%h exp=%h", cyc, obs, exp_w);
         else passed++;
      end
      xif.x_vld_i = 1'b0;
   endtask

   task automatic test_bubbles();
      logic [OW-1:0] exp_w;
      logic [RW-1:0] ew;
      hs_t.delete(); hs_v.delete();
      hs_t.push_back(5); hs_v.push_back(vec(0));
      hs_t.push_back(8); hs_v.push_back(vec(1));
      start = 1'b1; num_vec = 8'd2; xif.x_vld_i = 1'b0; xif.x_data_i = '0;
      for (int cyc = 1; cyc <= 19; cyc++) begin
         tick();
         start = 1'b0;
         xif.x_vld_i  = (cyc == 5 || cyc == 8);
         // Junk on bubble cycles must not leak into the skewed data.
         xif.x_data_i = (cyc == 5) ? vec(0) : (cyc == 8) ? vec(1) : {ROWS*X_W{1'b1}};
         model(cyc);
         ew = (cyc >= 1 && cyc <= 4) ? RW'(cyc - 1) : '0;
         exp_w = {(cyc >= 1 && cyc <= 4), ew, (cyc >= 5 && cyc <= 8),
                  e_v, e_d, e_m, (cyc <= 17), (cyc == 17)};
         checks++;
         if (obs !== exp_w) $display("FAIL bubbles cyc=%0d got=%h exp=%h", cyc, obs, exp_w);
         else passed++;
      end
      xif.x_vld_i = 1'b0; xif.x_data_i = '0;
   endtask

   task automatic test_abort();
      logic [OW-1:0] exp_w;
      logic [RW-1:0] ew;
      hs_t.delete(); hs_v.delete();
      hs_t.push_back(5); hs_v.push_back(vec(2));
      start = 1'b1; num_vec = 8'd3; xif.x_vld_i = 1'b1; xif.x_data_i = '0;
      for (int cyc = 1; cyc <= 10; cyc++) begin
         tick();
         start = 1'b0;
         xif.x_data_i = (cyc == 5) ? vec(2) : (cyc == 6) ? vec(3) : '0;
         abort = (cyc == 6);
         model(cyc);
         ew = (cyc >= 1 && cyc <= 4) ? RW'(cyc - 1) : '0;
         exp_w = {(cyc >= 1 && cyc <= 4), ew, (cyc >= 5 && cyc <= 6),
                  e_v, e_d, e_m, (cyc <= 6), 1'b0};
         if (cyc >= 7) exp_w = '0;
         checks++;
         if (obs !== exp_w) $display("FAIL abort cyc=%0d got=%h exp=%h", cyc, obs, exp_w);
         else passed++;
      end
      abort = 1'b0;
      // A fresh one-vector job after the abort runs normally.
      hs_t.delete(); hs_v.delete();
      hs_t.push_back(5); hs_v.push_back(vec(4));
      start = 1'b1; num_vec = 8'd1; xif.x_data_i = '0;
      for (int cyc = 1; cyc <= 16; cyc++) begin
         tick();
         start = 1'b0;
         xif.x_data_i = (cyc == 5) ? vec(4) : '0;
         model(cyc);
         ew = (cyc >= 1 && cyc <= 4) ? RW'(cyc - 1) : '0;
         exp_w = {(cyc >= 1 && cyc <= 4), ew, (cyc == 5),
                  e_v, e_d, e_m, (cyc <= 14), (cyc == 14)};
         checks++;
         if (obs !== exp_w) $display("FAIL restart cyc=%0d got=%h exp=%h", cyc, obs, exp_w);
         else passed++;
      end
      xif.x_vld_i = 1'b0;
   endtask

   task automatic test_zero_vec();
      logic [OW-1:0] exp_w;
      start = 1'b1; num_vec = 8'd0; xif.x_vld_i = 1'b1; xif.x_data_i = vec(5);
      for (int cyc = 1; cyc <= 4; cyc++) begin
         tick();
         start = 1'b0;
         exp_w = '0;
         exp_w[1] = (cyc == 1);
         exp_w[0] = (cyc == 1);
         checks++;
         if (obs !== exp_w) $display("FAIL zero_vec cyc=%0d got=%h exp=%h", cyc, obs, exp_w);
         else passed++;
      end
      xif.x_vld_i = 1'b0; xif.x_data_i = '0;
   endtask

   task automatic test_start_in_drain();
      logic [OW-1:0] exp_w;
      logic [RW-1:0] ew;
      hs_t.delete(); hs_v.delete();
      hs_t.push_back(5); hs_v.push_back(vec(6));
      hs_t.push_back(6); hs_v.push_back(vec(7));
      start = 1'b1; num_vec = 8'd2; xif.x_vld_i = 1'b1; xif.x_data_i = '0;
      for (int cyc = 1; cyc <= 24; cyc++) begin
         tick();
         // Second start with a different count lands mid-drain.
         start   = (cyc == 9);
         num_vec = (cyc == 9) ? 8'd5 : 8'd2;
         xif.x_data_i = (cyc == 5) ? vec(6) : (cyc == 6) ? vec(7) : '0;
         model(cyc);
         ew = (cyc >= 1 && cyc <= 4) ? RW'(cyc - 1) : '0;
         exp_w = {(cyc >= 1 && cyc <= 4), ew, (cyc >= 5 && cyc <= 6),
                  e_v, e_d, e_m, (cyc <= 15), (cyc == 15)};
         checks++;
         if (obs !== exp_w) $display("FAIL start_in_drain cyc=%0d got=%h exp=%h", cyc, obs, exp_w);
         else passed++;
      end
      start = 1'b0; xif.x_vld_i = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_bubbles();
      test_abort();
      test_zero_vec();
      test_start_in_drain();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
`default_nettype wire
